// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM encoding for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } dump_state_e;

    // ABI register indices
    localparam int unsigned ABI_ZERO = 0;
    localparam int unsigned ABI_RA   = 1;
    localparam int unsigned ABI_SP   = 2;
    localparam int unsigned ABI_T6   = 31;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Sequential dump engine: walks every register index over a valid/ready stream.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dump_start,
    input  logic            dump_ready,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic            dump_done,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic [AW-1:0]   o_rd_addr,
    input  logic [XLEN-1:0] i_rd_data
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    dump_state_e     r_state, w_state_nxt;
    logic [AW-1:0]   r_idx, w_idx_nxt;
    logic [XLEN-1:0] r_data, w_data_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Data is captured once per entry, so a stalled beat keeps its snapshot.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        o_rd_addr   = '0;
        unique case (r_state)
            StIdle: begin
                if (dump_start) begin
                    w_state_nxt = StRun;
                    w_idx_nxt   = '0;
                    w_data_nxt  = i_rd_data;
                end
            end
            StRun: begin
                o_rd_addr = r_idx + AW'(1);
                if (dump_ready) begin
                    if (r_idx == LastIdx) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_idx_nxt  = r_idx + AW'(1);
                        w_data_nxt = i_rd_data;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign dump_busy  = (r_state != StIdle);
    assign dump_valid = (r_state == StRun);
    assign dump_done  = (r_state == StDone);
    assign dump_idx   = r_idx;
    assign dump_data  = r_data;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write lanes, NRD combinational reads,
// optional write-to-read bypass and a register dump stream.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned NREGS   = NREGS_DEFAULT,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter int unsigned NRD     = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned DBG_IDX = ABI_T6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [1:0]          we,
    input  logic [2*AW-1:0]     wa,
    input  logic [2*XLEN-1:0]   wd,
    input  logic                dump_start,
    output logic                dump_busy,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_done,
    output logic [XLEN-1:0]     dbg_reg
);

    localparam logic [AW-1:0] DbgAddr  = AW'(DBG_IDX);
    localparam bit            BypassEn = (BYPASS != 0);

    // Entry 0 is reset and never written, so it always reads zero.
    logic [XLEN-1:0] r_regs [NREGS];

    logic [AW-1:0]   w_wa0, w_wa1;
    logic [XLEN-1:0] w_wd0, w_wd1;
    logic            w_wen0, w_wen1;
    logic [AW-1:0]   w_dump_addr;
    logic [XLEN-1:0] w_dump_rdata;

    assign w_wa0  = wa[0  +: AW];
    assign w_wa1  = wa[AW +: AW];
    assign w_wd0  = wd[0    +: XLEN];
    assign w_wd1  = wd[XLEN +: XLEN];
    assign w_wen0 = we[0] && (w_wa0 != '0);
    assign w_wen1 = we[1] && (w_wa1 != '0);

    // Lane 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wen0) r_regs[w_wa0] <= w_wd0;
            if (w_wen1) r_regs[w_wa1] <= w_wd1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_hit0, w_hit1;

        assign w_a    = ra[k*AW +: AW];
        assign w_hit0 = BypassEn && w_wen0 && (w_wa0 == w_a);
        assign w_hit1 = BypassEn && w_wen1 && (w_wa1 == w_a);
        assign rd[k*XLEN +: XLEN] = w_hit1 ? w_wd1 :
                                    w_hit0 ? w_wd0 : r_regs[w_a];
    end

    assign dbg_reg      = r_regs[DbgAddr];
    assign w_dump_rdata = r_regs[w_dump_addr];

    regfile_dump_fsm #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump (
        .clk        (clk),
        .rstn       (rstn),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_done  (dump_done),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .o_rd_addr  (w_dump_addr),
        .i_rd_data  (w_dump_rdata)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed reads/writes plus a dump-stream scoreboard.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd, rd_nb;
    logic [1:0]          we;
    logic [2*AW-1:0]     wa;
    logic [2*XLEN-1:0]   wd;
    logic                dump_start, dump_ready;
    logic                dump_busy, dump_valid, dump_done;
    logic [AW-1:0]       dump_idx;
    logic [XLEN-1:0]     dump_data, dbg_reg;
    logic                nb_busy, nb_valid, nb_done;
    logic [AW-1:0]       nb_idx;
    logic [XLEN-1:0]     nb_data, nb_dbg;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .DBG_IDX(31)) u_dut (
        .clk(clk), .rstn(rstn), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done), .dbg_reg(dbg_reg)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .DBG_IDX(31)) u_dut_nb (
        .clk(clk), .rstn(rstn), .ra(ra), .rd(rd_nb), .we(we), .wa(wa), .wd(wd),
        .dump_start(1'b0), .dump_busy(nb_busy), .dump_valid(nb_valid),
        .dump_ready(1'b1), .dump_idx(nb_idx), .dump_data(nb_data),
        .dump_done(nb_done), .dbg_reg(nb_dbg)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_beats = 0;
    logic prev_last = 1'b0;
    logic [AW+XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected entry per accepted dump beat.
    always @(negedge clk) begin
        if (dump_done || prev_last)
            chk("done_timing", 64'(dump_done), 64'(prev_last));
        if (dump_done) n_done++;
        if (dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL dump_unexpected: got %h expected none", {dump_idx, dump_data});
            end else begin
                chk("dump_beat", 64'({dump_idx, dump_data}), 64'(exp_q.pop_front()));
                n_beats++;
            end
        end else if (dump_valid && exp_q.size() > 0) begin
            chk("dump_stall_hold", 64'({dump_idx, dump_data}), 64'(exp_q[0]));
        end
        prev_last = dump_valid && dump_ready && (dump_idx == AW'(NREGS - 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] e, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                      input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        we = e;
        wa = {a1, a0};
        wd = {d1, d0};
        tick();
        we = 2'b00;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!dump_done && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL done_timeout: got no dump_done expected pulse");
        end
    endtask

    task automatic wait_idx(input logic [AW-1:0] idx);
        int k = 0;
        while (!(dump_valid && dump_idx == idx) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL idx_timeout: got idx %0d expected %0d", dump_idx, idx);
        end
    endtask

    initial begin
        int k;
        int done_base;
        rstn = 1'b0; ra = '0; we = '0; wa = '0; wd = '0;
        dump_start = 1'b0; dump_ready = 1'b1;
        #12 rstn = 1'b1;
        tick();

        // Reset state
        ra[0 +: AW] = 5'd5;
        #1;
        chk("rst_busy", 64'(dump_busy), 64'h0);
        chk("rst_valid", 64'(dump_valid), 64'h0);
        chk("rst_idx_data", 64'({dump_idx, dump_data}), 64'h0);
        chk("rst_rd0", 64'(rd[0 +: XLEN]), 64'h0);

        wr(2'b11, 5'd5, 32'hDEADBEEF, 5'd31, 32'h0000CAFE);
        chk("wr_x5", 64'(rd[0 +: XLEN]), 64'hDEADBEEF);
        chk("dbg_x31", 64'(dbg_reg), 64'h0000CAFE);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_rd", 64'(rd[0 +: XLEN]), 64'h0);
        chk("async_rst_dbg", 64'(dbg_reg), 64'h0);
        #1 rstn = 1'b1;
        tick();

        // Writes to x0 are dropped on both lanes, bypass included
        ra[0 +: AW] = 5'd0;
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h1234, 32'h1234};
        #1;
        chk("x0_bypass", 64'(rd[0 +: XLEN]), 64'h0);
        tick();
        we = 2'b00;
        chk("x0_stored", 64'(rd_nb[0 +: XLEN]), 64'h0);

        // Same-address collision: lane 1 wins; distinct addresses both land
        wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        ra[0 +: AW] = 5'd7;
        #1 chk("collide_x7", 64'(rd_nb[0 +: XLEN]), 64'h22);
        wr(2'b11, 5'd3, 32'hA, 5'd4, 32'hB);
        ra = {5'd4, 5'd3};
        #1;
        chk("dual_x3", 64'(rd_nb[0 +: XLEN]), 64'hA);
        chk("dual_x4", 64'(rd_nb[XLEN +: XLEN]), 64'hB);

        // Bypass vs stored reads
        wr(2'b01, 5'd9, 32'h5, 5'd0, 32'h0);
        ra = {5'd31, 5'd9};
        we = 2'b11; wa = {5'd31, 5'd9}; wd = {32'h99, 32'h77};
        #1;
        chk("byp_rd0", 64'(rd[0 +: XLEN]), 64'h77);
        chk("nobyp_rd0", 64'(rd_nb[0 +: XLEN]), 64'h5);
        chk("byp_rd1", 64'(rd[XLEN +: XLEN]), 64'h99);
        chk("dbg_not_bypassed", 64'(dbg_reg), 64'h0);
        tick();
        we = 2'b00;
        #1;
        chk("nobyp_next", 64'(rd_nb[0 +: XLEN]), 64'h77);
        chk("dbg_after_wr", 64'(dbg_reg), 64'h99);
        we = 2'b11; wa = {5'd9, 5'd9}; wd = {32'h2, 32'h1};
        #1 chk("byp_lane1_prio", 64'(rd[0 +: XLEN]), 64'h2);
        tick();
        we = 2'b00;

        // Dump with ready held high
        for (int i = 1; i < NREGS; i++) wr(2'b01, AW'(i), 32'(i * 'h100), 5'd0, 32'h0);
        for (int i = 0; i < NREGS; i++) exp_q.push_back({AW'(i), 32'(i * 'h100)});
        n_beats = 0;
        done_base = n_done;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_done(k);
        chk("dump_consecutive", 64'(k), 64'd32);
        tick();
        tick();
        chk("dump1_busy_after", 64'(dump_busy), 64'h0);
        chk("dump1_beats", 64'(n_beats), 64'd32);
        chk("dump1_done_cnt", 64'(n_done - done_base), 64'd1);

        // Stall at idx 10 with a concurrent write; start held high throughout
        for (int i = 0; i < NREGS; i++) exp_q.push_back({AW'(i), 32'(i * 'h100)});
        n_beats = 0;
        done_base = n_done;
        dump_start = 1'b1;
        tick();
        wait_idx(5'd10);
        dump_ready = 1'b0;
        we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'hFFFF};
        repeat (5) tick();
        we = 2'b00;
        dump_ready = 1'b1;
        wait_done(k);
        tick();
        dump_start = 1'b0;
        tick();
        chk("dump2_busy_after", 64'(dump_busy), 64'h0);
        chk("dump2_valid_after", 64'(dump_valid), 64'h0);
        chk("dump2_beats", 64'(n_beats), 64'd32);
        chk("dump2_done_cnt", 64'(n_done - done_base), 64'd1);
        chk("dump2_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-dump at idx 20
        for (int i = 0; i < 20; i++)
            exp_q.push_back({AW'(i), (i == 10) ? 32'hFFFF : 32'(i * 'h100)});
        n_beats = 0;
        done_base = n_done;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_idx(5'd20);
        rstn = 1'b0;
        ra = {5'd11, 5'd10};
        #1;
        chk("mid_rst_valid", 64'(dump_valid), 64'h0);
        chk("mid_rst_busy", 64'(dump_busy), 64'h0);
        chk("mid_rst_regs", 64'({rd_nb[XLEN +: XLEN], rd_nb[0 +: XLEN]}), 64'h0);
        chk("mid_rst_beats", 64'(n_beats), 64'd20);
        #1 rstn = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_done", 64'(n_done - done_base), 64'd0);

        for (int i = 0; i < NREGS; i++) exp_q.push_back({AW'(i), 32'h0});
        n_beats = 0;
        done_base = n_done;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_done(k);
        tick();
        tick();
        chk("dump3_beats", 64'(n_beats), 64'd32);
        chk("dump3_done_cnt", 64'(n_done - done_base), 64'd1);
        chk("dump3_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read core register file.
- Adds configurable XLEN/depth/read-port count, a second write port, optional write-to-read bypass, reset clearing and a sequential dump engine.
- The dump engine streams every register over a valid/ready handshake to the debug/trace unit.
- Sits in the core datapath between decode (read addresses) and writeback (two retire lanes).

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of 2, >=2); index 0 hardwired zero
AW, $clog2(NREGS), address width (derived, not overridden)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
DBG_IDX, 31, register index driven on dbg_reg

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
ra  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
rd  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
we  in  2  write enables, lane 0 and lane 1
wa  in  2*AW  packed write addresses
wd  in  2*XLEN  packed write data
dump_start  in  1  request full register dump
dump_busy  out  1  dump engine not IDLE
dump_valid  out  1  dump_idx/dump_data valid
dump_ready  in  1  consumer accepts current entry
dump_idx  out  AW  index of current entry
dump_data  out  XLEN  value of current entry
dump_done  out  1  one-cycle pulse after last entry accepted
dbg_reg  out  XLEN  live contents of register DBG_IDX (0 if DBG_IDX==0)

Behaviour:
- Reset (rstn low, async): all registers 1..NREGS-1 = 0; FSM IDLE; dump_busy/dump_valid/dump_done = 0; dump_idx = 0; dump_data = 0. Reset mid-dump aborts the dump with no done pulse.
- Register 0: reads always 0; writes to index 0 dropped on either lane.
- Writes on rising clk: lane w writes when we[w] && wa[w]!=0. Both lanes to same nonzero address: lane 1 wins.
- Reads are combinational, zero latency.
  - BYPASS=0: rd returns the stored (pre-edge) value.
  - BYPASS=1: if ra matches an enabled nonzero write address this cycle, rd = that wd (lane 1 priority); else stored value.
- dbg_reg is stored value only, never bypassed.
- Dump FSM, states IDLE, RUN, DONE:
  - IDLE: dump_start=1 -> RUN. dump_idx=0, dump_data=regs[0]=0, dump_valid=1 next cycle.
  - RUN: dump_valid=1 held.
    - Entry accepted on dump_valid && dump_ready.
    - Accept with dump_idx<NREGS-1: dump_idx+1; dump_data loaded with the stored (pre-edge) value of the next index.
    - Accept with dump_idx==NREGS-1 -> DONE, dump_valid=0.
  - DONE: dump_done=1 for exactly one cycle -> IDLE. dump_busy=1 in RUN and DONE.
  - dump_data is a register: stable while stalled, even if the entry's register is written during the stall (snapshot semantics per entry).
  - dump_start ignored unless IDLE; dump_start in the DONE cycle ignored.
  - Datapath writes are never blocked by a dump.
- Widths: no arithmetic on data. dump_idx wraps only via the FSM; no overflow past NREGS-1.

Decomposition:
- Shared package regfile_pkg: default XLEN/NREGS constants, dump FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), ABI index constants (ZERO=0, RA=1, SP=2, T6=31).
- One natural sub-module: regfile_dump_fsm (state, dump_idx counter, handshake, done pulse). It takes a read-address output and a read-data input from the array. Storage, write lanes and bypass muxes stay in regfile_mp.

Test Plan:
- Reset then read all: assert rstn=0 mid-run. All rd=0 and dbg_reg=0 immediately (async). Write x5=0xDEADBEEF, read ra0=5 -> 0xDEADBEEF next cycle. Write x0=0x1234 -> rd stays 0.
- Dual write collision: we=2'b11, wa0=wa1=7, wd0=0x11, wd1=0x22 -> x7=0x22. wa0=3/wd0=0xA, wa1=4/wd1=0xB same cycle -> both stored.
- Bypass: BYPASS=1, x9=0x5, same cycle write x9=0x77 and ra0=9 -> rd=0x77 that cycle. BYPASS=0 build -> rd=0x5 that cycle, 0x77 next cycle. dbg_reg never bypassed.
- Dump, ready always 1: preload xi=i*0x100. Pulse dump_start -> 32 consecutive valid beats, idx 0..31, data 0,0x100..0x1F00. dump_done high exactly 1 cycle after idx31 accepted; dump_busy low after.
- Dump with stalls and concurrent write: ready low 5 cycles at idx=10 while writing x10=0xFFFF -> dump_data holds 0xA00 throughout. Next entry idx11=0xB00. dump_start pulses during RUN ignored (single dump, 32 beats).
- Reset mid-dump at idx=20 -> dump_valid/busy 0 immediately, no dump_done, regs cleared. A new dump_start then streams 32 zeros.
